// File: rtl/flash_pkg.sv
// flash_pkg: shared state encoding, flash command bytes, status-register bit
// positions and the byte-lane decode used by the flash programmer.
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_POLL = 3'd3,
    ST_CLR  = 3'd4,
    ST_ACK  = 3'd5
  } state_e;

  localparam logic [7:0] CMD_PROG       = 8'h40;
  localparam logic [7:0] CMD_ERASE      = 8'h20;
  localparam logic [7:0] CMD_CONFIRM    = 8'hD0;
  localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;

  // Flash status register bits
  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;

  localparam logic [7:0] STATUS_RST = 8'h80;

  // Latched operation: erase flag plus the byte driven in the DATA phase
  typedef struct packed {
    logic       erase;
    logic [7:0] wbyte;
  } op_t;

  // Byte-lane decode result; ok=0 when sel is not one-hot
  typedef struct packed {
    logic       ok;
    logic [1:0] lane;
  } lane_t;

  // Big-endian lane: sel[3] is byte 0 of the word
  function automatic lane_t sel_lane(input logic [3:0] sel);
    lane_t r;
    r.ok   = 1'b1;
    r.lane = 2'd0;
    case (sel)
      4'b1000: r.lane = 2'd0;
      4'b0100: r.lane = 2'd1;
      4'b0010: r.lane = 2'd2;
      4'b0001: r.lane = 2'd3;
      default: r.ok   = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flash_phase.sv
// flash_phase: per-phase bus timer. A phase is WS strobe cycles followed by
// one recovery cycle; the counter wraps by itself so back-to-back phases
// (repeated polls) need no restart, and clr realigns it on a state change.
module flash_phase #(
  parameter int WS = 5
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic run,
  input  logic clr,
  output logic strobe,
  output logic last,
  output logic phase_done
);

  localparam int CW = $clog2(WS + 1);

  logic [CW-1:0] cnt;

  // Cycle counter within the current phase
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || !run || clr || phase_done) cnt <= '0;
    else                                       cnt <= cnt + 1'b1;
  end

  assign strobe     = run && (cnt <  CW'(WS));
  assign last       = run && (cnt == CW'(WS - 1));
  assign phase_done = run && (cnt == CW'(WS));

endmodule

// File: rtl/flash_prog.sv
// flash_prog: Wishbone slave that programs/erases an 8-bit parallel flash
// using the 0x40 / 0x20-0xD0 command sets, polls the status register until
// ready and returns the part to read-array mode before acking.
// Optional feature: define FLASH_PROG_TIMEOUT_EN to bound status polling
// to TMO clock cycles (sets the tmo sticky bit on expiry).
module flash_prog
  import flash_pkg::*;
#(
  parameter int          WS  = 5,
  parameter logic [23:0] TMO = 24'hFFFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [31:0] flash_adr_o,
  output logic [7:0]  flash_dat_o,
  input  logic [7:0]  flash_dat_i,
  output logic        flash_dat_t,
  output logic        flash_ce,
  output logic        flash_oe,
  output logic        flash_we,
  output logic        flash_rst,
  output logic        flash_byte_cfg
);

  state_e     state, state_n;
  op_t        op;
  lane_t      ln;
  logic [7:0] status;
  logic       perr, tmo, badsel;
  logic       accept;
  logic       ph_run, ph_clr, ph_strobe, ph_last, ph_done;
  logic       poll_ready, tmo_hit;

  assign accept     = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign ln         = sel_lane(wb_sel_i);
  assign poll_ready = ph_done && status[SR_READY];

  assign flash_rst      = wb_rst_i;
  assign flash_byte_cfg = 1'b0;

  // Upper address byte and word offset never reach the flash
  logic unused_adr;
  assign unused_adr = &{1'b0, wb_adr_i[31:24], wb_adr_i[1:0]};

  assign ph_run = (state == ST_CMD) || (state == ST_DATA) ||
                  (state == ST_POLL) || (state == ST_CLR);
  assign ph_clr = (state_n != state);

  flash_phase #(.WS(WS)) u_phase (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .run        (ph_run),
    .clr        (ph_clr),
    .strobe     (ph_strobe),
    .last       (ph_last),
    .phase_done (ph_done)
  );

`ifdef FLASH_PROG_TIMEOUT_EN
  logic [23:0] tcnt;

  // Counts cycles spent in POLL; zero on every entry
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || state != ST_POLL) tcnt <= '0;
    else                               tcnt <= tcnt + 24'd1;
  end

  assign tmo_hit = (state == ST_POLL) && (tcnt == TMO - 24'd1);
`else
  logic [23:0] unused_tmo;
  assign unused_tmo = TMO;
  assign tmo_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) state <= ST_IDLE;
    else           state <= state_n;
  end

  // Next state and flash/Wishbone strobes decoded from the current state
  always_comb begin
    state_n     = state;
    flash_ce    = 1'b1;
    flash_oe    = 1'b1;
    flash_we    = 1'b1;
    flash_dat_t = 1'b1;
    flash_dat_o = 8'h00;
    wb_ack_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!wb_we_i || wb_adr_i[23])    state_n = ST_ACK;
          else if (wb_adr_i[22] || ln.ok)  state_n = ST_CMD;
          else                             state_n = ST_ACK;
        end
      end
      ST_CMD: begin
        flash_dat_t = 1'b0;
        flash_dat_o = op.erase ? CMD_ERASE : CMD_PROG;
        flash_ce    = ~ph_strobe;
        flash_we    = ~ph_strobe;
        if (ph_done) state_n = ST_DATA;
      end
      ST_DATA: begin
        flash_dat_t = 1'b0;
        flash_dat_o = op.erase ? CMD_CONFIRM : op.wbyte;
        flash_ce    = ~ph_strobe;
        flash_we    = ~ph_strobe;
        if (ph_done) state_n = ST_POLL;
      end
      ST_POLL: begin
        flash_ce = ~ph_strobe;
        flash_oe = ~ph_strobe;
        if (poll_ready || tmo_hit) state_n = ST_CLR;
      end
      ST_CLR: begin
        flash_dat_t = 1'b0;
        flash_dat_o = CMD_READ_ARRAY;
        flash_ce    = ~ph_strobe;
        flash_we    = ~ph_strobe;
        if (ph_done) state_n = ST_ACK;
      end
      ST_ACK: begin
        // A master that walked away gets no ack
        wb_ack_o = wb_cyc_i && wb_stb_i;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request latch, status capture and sticky error bits
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      op          <= '0;
      flash_adr_o <= '0;
      wb_dat_o    <= '0;
      status      <= STATUS_RST;
      perr        <= 1'b0;
      tmo         <= 1'b0;
      badsel      <= 1'b0;
    end else begin
      if (accept) begin
        if (!wb_we_i) begin
          wb_dat_o <= {21'b0, badsel, tmo, perr, status};
        end else if (wb_adr_i[23]) begin
          perr   <= 1'b0;
          tmo    <= 1'b0;
          badsel <= 1'b0;
        end else if (wb_adr_i[22]) begin
          op.erase    <= 1'b1;
          op.wbyte    <= 8'h00;
          flash_adr_o <= {10'b0, wb_adr_i[21:2], 2'b00};
        end else if (ln.ok) begin
          op.erase    <= 1'b0;
          op.wbyte    <= lane_byte(wb_dat_i, ln.lane);
          flash_adr_o <= {10'b0, wb_adr_i[21:2], ln.lane};
        end else begin
          badsel <= 1'b1;
        end
      end
      if (state == ST_POLL && ph_last)
        status <= flash_dat_i;
      if (state == ST_POLL && ph_done &&
          (status[SR_PROG_ERR] || status[SR_ERASE_ERR]))
        perr <= 1'b1;
      if (tmo_hit && !poll_ready)
        tmo <= 1'b1;
    end
  end

endmodule
